bg7_engine: RTL and testbench
=============================

Name: bg7_engine

Overview:
- Next-generation Mode 7 background engine for the PPU.
- Replaces per-dot matrix multiplication with a per-line setup FSM (two shared signed multipliers) plus per-dot incremental accumulators.
- Adds the following over the current engine: screen-over modes, horizontal mosaic, EXTBG priority split, and a parametrised map size and fixed-point format.
- Sits beside the other BG units and is driven by the shared dot_en/x/y timing; drives VRAM low/high byte addresses.

Parameters:
MAP_TILES_LOG2, 7, log2 of map side in tiles (legal 5..7); map side in pixels = 2^(MAP_TILES_LOG2+3)
FRAC_BITS, 8, fractional bits of the matrix coefficients and accumulators
COORD_W, 13, signed width of scroll/origin registers
ACC_W, 28, signed accumulator width; must be >= 16+COORD_W-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dot_en  in  1  one-clk pixel strobe
line_start  in  1  one-clk pulse, at least 3 clk before the first dot_en of a line; y valid
x  in  8  current screen x (informational; the accumulator is authoritative)
y  in  8  screen y, already vertically mosaic-quantised by the caller
m7sel  in  8  [0]=hflip, [1]=vflip, [7:6]=screen-over mode
m7_a, m7_b, m7_c, m7_d  in  16 each  signed matrix coefficients
m7_xofs, m7_yofs, m7_xorig, m7_yorig  in  COORD_W each  signed scroll/origin values
mosaic_size  in  4  block size minus 1
mosaic_en  in  1  horizontal mosaic enable for this BG
extbg  in  1  EXTBG mode
vram_l_addr  out  15  tilemap byte address
vram_h_addr  out  15  tile data byte address
vram_rdata_l, vram_rdata_h  in  8 each  VRAM read data, valid the clk after the address
pixel_color  out  8  palette index
pixel_prio  out  1  EXTBG priority bit
pixel_valid  out  1  pixel opaque
busy  out  1  setup in progress

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulators, pipeline and mosaic counter cleared.
- FSM states: IDLE -> (line_start) SETUP_X -> SETUP_Y -> RUN -> (line_start) SETUP_X.
  - line_start in any state, including mid-setup, restarts at SETUP_X.
  - busy = 1 in SETUP_X and SETUP_Y.
  - dot_en arriving during setup is ignored; no pixel is emitted for it.
- Setup values:
  - yp = vflip ? ~y : y
  - x0 = hflip ? 255 : 0
  - dx = xofs - xorig
  - dy = yp + yofs - yorig
- SETUP_X: accx <= A*(x0+dx) + B*dy + (xorig << FRAC_BITS).
- SETUP_Y: accy <= C*(x0+dx) + D*dy + (yorig << FRAC_BITS).
- RUN, each dot_en:
  - If mosaic_en and mosaic counter != mosaic_size: increment the counter and hold both accumulators.
  - Otherwise: clear the counter; accx += hflip ? -A : A; accy += hflip ? -C : C.
  - The counter clears at setup.
  - Stage 0 captures the current accx/accy before the increment.
- Coordinates:
  - px = acc[FRAC_BITS +: MAP_TILES_LOG2+3].
  - over = 1 if any bit above that field is nonzero (sign-extended; negative counts as over).
- Pipeline, one stage per dot_en:
  - S0 registers px, py, over.
  - S1 drives vram_l_addr = zero-extended {py tile, px tile}, latches the fine bits, and captures tile = vram_rdata_l (forced to 0 in mode 3 when over).
  - S2 drives vram_h_addr = {tile, py[2:0], px[2:0]} and captures data = vram_rdata_h.
  - Output registers update on the following dot_en.
  - Latency: the pixel for a dot appears 3 dot_en after its S0 capture.
- Screen-over mode m7sel[7:6]:
  - 0 or 1: wrap (high bits ignored).
  - 2: pixel_valid forced 0.
  - 3: tile 0 is used; fine bits still come from the coordinate.
- Output mapping:
  - extbg = 1: pixel_color = {0, data[6:0]}, pixel_prio = data[7].
  - extbg = 0: pixel_color = data, pixel_prio = 0.
  - pixel_valid = (pixel_color != 0) and not mode-2 over.
- Arithmetic: all signed, two's complement, truncated to ACC_W; accumulator overflow wraps silently.
- Register changes: matrix and scroll inputs are sampled only at setup; changes mid-line take effect at the next line_start.

Decomposition:
- ppu_pkg gains:
  - m7_overflow_e (WRAP, TRANSPARENT, TILE0)
  - m7_pixel_t (color, prio, valid)
  - the M7 map-size derived width constants
- Sub-module bg7_coord_acc: setup multiplier plus accumulator plus mosaic counter, instantiated once; it handles the X and Y channels internally.

Test Plan:
- Identity matrix (A=D=0x0100, B=C=0), offsets 0, map cell (0,0)=tile 5, tile 5 row0 = 1..8 -> pixels 1..8 at x=0..7, 3 dot_en latency, vram_l_addr=0, vram_h_addr=0x140..0x147.
- A=0x0080 (2x zoom) -> each texel repeats for 2 dots; hflip=1 with A=0x0100 -> first pixel from px=255.
- xofs=-8, mode 2 -> first 8 pixels pixel_valid=0; mode 3 -> tile 0 data shown; mode 0 -> texels from px=1016..1023.
- mosaic_en=1, mosaic_size=3 -> px advances every 4 dots (0,0,0,0,4,...).
- extbg=1, data=0x85 -> color=0x05, prio=1; data=0x80 -> valid=0.
- line_start during SETUP_Y, then async reset asserted mid-RUN -> restart at SETUP_X; all outputs 0 immediately on reset.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU types and Mode 7 map geometry.
// Engine parameters default to the constants below.
package ppu_pkg;

  localparam int M7_MAP_TILES_LOG2 = 7;
  localparam int M7_FRAC_BITS      = 8;
  localparam int M7_COORD_W        = 13;
  localparam int M7_ACC_W          = 28;
  localparam int M7_PX_W  = M7_MAP_TILES_LOG2 + 3;
  localparam int M7_VRAM_AW        = 15;

  typedef enum logic [1:0] {
    M7_WRAP,
    M7_TRANSPARENT,
    M7_TILE0
  } m7_overflow_e;

  typedef struct packed {
    logic [7:0] color;
    logic       prio;
    logic       valid;
  } m7_pixel_t;

  function automatic m7_overflow_e m7_ovf_mode(
    input logic [1:0] sel
  );
    m7_overflow_e m;
    unique case (sel)
      2'd2:    m = M7_TRANSPARENT;
      2'd3:    m = M7_TILE0;
      default: m = M7_WRAP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bg7_coord_acc.sv
// bg7_coord_acc: per-line matrix setup on a shared multiplier
// pair, then per-dot incremental X/Y accumulators with mosaic.
module bg7_coord_acc
  import ppu_pkg::*;
#(
  parameter int FRAC_BITS = M7_FRAC_BITS,
  parameter int COORD_W   = M7_COORD_W,
  parameter int ACC_W     = M7_ACC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               setup_x,
  input  logic               setup_y,
  input  logic               step,
  input  logic               hflip,
  input  logic               vflip,
  input  logic [7:0]         y,
  input  logic [15:0]        m7_a,
  input  logic [15:0]        m7_b,
  input  logic [15:0]        m7_c,
  input  logic [15:0]        m7_d,
  input  logic [COORD_W-1:0] xofs,
  input  logic [COORD_W-1:0] yofs,
  input  logic [COORD_W-1:0] xorig,
  input  logic [COORD_W-1:0] yorig,
  input  logic               mosaic_en,
  input  logic [3:0]         mosaic_size,
  output logic [ACC_W-1:0]   accx,
  output logic [ACC_W-1:0]   accy
);

  localparam int CE = ACC_W - COORD_W;
  localparam int KE = ACC_W - 16;

  logic signed [ACC_W-1:0] xofs_s, yofs_s;
  logic signed [ACC_W-1:0] xorig_s, yorig_s;
  logic signed [ACC_W-1:0] x0_s, yp_s, ux, uy;
  logic signed [ACC_W-1:0] a_s, b_s, c_s, d_s;
  logic signed [ACC_W-1:0] k1, k2, org, prod;
  logic signed [ACC_W-1:0] sa_s, sc_s, stepx, stepy;
  logic signed [ACC_W-1:0] accx_q, accx_d;
  logic signed [ACC_W-1:0] accy_q, accy_d;
  logic [15:0] a_q, c_q;
  logic        hflip_q;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [7:0]  yp;

  assign xofs_s  = $signed({{CE{xofs[COORD_W-1]}}, xofs});
  assign yofs_s  = $signed({{CE{yofs[COORD_W-1]}}, yofs});
  assign xorig_s = $signed({{CE{xorig[COORD_W-1]}}, xorig});
  assign yorig_s = $signed({{CE{yorig[COORD_W-1]}}, yorig});

  assign a_s = $signed({{KE{m7_a[15]}}, m7_a});
  assign b_s = $signed({{KE{m7_b[15]}}, m7_b});
  assign c_s = $signed({{KE{m7_c[15]}}, m7_c});
  assign d_s = $signed({{KE{m7_d[15]}}, m7_d});

  assign yp   = vflip ? ~y : y;
  assign yp_s = $signed({{(ACC_W-8){1'b0}}, yp});
  assign x0_s = hflip ? ACC_W'(255) : '0;
  assign ux   = x0_s + xofs_s - xorig_s;
  assign uy   = yp_s + yofs_s - yorig_s;

  // A/B feed the multipliers in SETUP_X, C/D in SETUP_Y
  assign k1   = setup_y ? c_s : a_s;
  assign k2   = setup_y ? d_s : b_s;
  assign org  = (setup_y ? yorig_s : xorig_s) <<< FRAC_BITS;
  assign prod = k1 * ux + k2 * uy + org;

  assign sa_s  = $signed({{KE{a_q[15]}}, a_q});
  assign sc_s  = $signed({{KE{c_q[15]}}, c_q});
  assign stepx = hflip_q ? -sa_s : sa_s;
  assign stepy = hflip_q ? -sc_s : sc_s;

  always_comb begin
    accx_d = accx_q;
    accy_d = accy_q;
    mcnt_d = mcnt_q;
    if (setup_x) begin
      accx_d = prod;
      mcnt_d = '0;
    end else if (setup_y) begin
      accy_d = prod;
      mcnt_d = '0;
    end else if (step) begin
      if (mosaic_en && mcnt_q != mosaic_size) begin
        mcnt_d = mcnt_q + 4'd1;
      end else begin
        mcnt_d = '0;
        accx_d = accx_q + stepx;
        accy_d = accy_q + stepy;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accx_q  <= '0;
      accy_q  <= '0;
      mcnt_q  <= '0;
      a_q     <= '0;
      c_q     <= '0;
      hflip_q <= 1'b0;
    end else begin
      accx_q <= accx_d;
      accy_q <= accy_d;
      mcnt_q <= mcnt_d;
      if (setup_x) begin
        a_q     <= m7_a;
        c_q     <= m7_c;
        hflip_q <= hflip;
      end
    end
  end

  assign accx = accx_q;
  assign accy = accy_q;

endmodule

// File: rtl/bg7_engine.sv
// bg7_engine: Mode 7 background engine; setup FSM, coordinate
// accumulators and a three-stage VRAM fetch pipeline on dot_en.
module bg7_engine
  import ppu_pkg::*;
#(
  parameter int MAP_TILES_LOG2 = M7_MAP_TILES_LOG2,
  parameter int FRAC_BITS      = M7_FRAC_BITS,
  parameter int COORD_W        = M7_COORD_W,
  parameter int ACC_W          = M7_ACC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dot_en,
  input  logic               line_start,
  input  logic [7:0]         x,
  input  logic [7:0]         y,
  input  logic [7:0]         m7sel,
  input  logic [15:0]        m7_a,
  input  logic [15:0]        m7_b,
  input  logic [15:0]        m7_c,
  input  logic [15:0]        m7_d,
  input  logic [COORD_W-1:0] m7_xofs,
  input  logic [COORD_W-1:0] m7_yofs,
  input  logic [COORD_W-1:0] m7_xorig,
  input  logic [COORD_W-1:0] m7_yorig,
  input  logic [3:0]         mosaic_size,
  input  logic               mosaic_en,
  input  logic               extbg,
  output logic [14:0]        vram_l_addr,
  output logic [14:0]        vram_h_addr,
  input  logic [7:0]         vram_rdata_l,
  input  logic [7:0]         vram_rdata_h,
  output logic [7:0]         pixel_color,
  output logic               pixel_prio,
  output logic               pixel_valid,
  output logic               busy
);

  localparam int PXW = MAP_TILES_LOG2 + 3;
  localparam int OVL = FRAC_BITS + PXW;

  typedef enum logic [1:0] {
    IDLE,
    SETUP_X,
    SETUP_Y,
    RUN
  } state_e;

  state_e state_q, state_d;
  m7_overflow_e ovf_q;

  logic [ACC_W-1:0] accx, accy;
  logic             adv, setup_x, setup_y;
  logic             over_now;

  logic [PXW-1:0] s0_px_q, s0_py_q;
  logic           s0_over_q;
  logic [7:0]     s1_tile_q, s1_tile_d;
  logic [2:0]     s1_fx_q, s1_fy_q;
  logic           s1_over_q;
  logic [7:0]     s2_data_q;
  logic           s2_over_q;
  m7_pixel_t      pix_q, pix_d;
  logic           unused_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      SETUP_X: state_d = SETUP_Y;
      SETUP_Y: state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (line_start) state_d = SETUP_X;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ovf_q   <= M7_WRAP;
    end else begin
      state_q <= state_d;
      if (state_q == SETUP_X) ovf_q <= m7_ovf_mode(m7sel[7:6]);
    end
  end

  assign setup_x = (state_q == SETUP_X);
  assign setup_y = (state_q == SETUP_Y);
  assign busy    = setup_x | setup_y;
  assign adv     = (state_q == RUN) & dot_en;

  bg7_coord_acc #(
    .FRAC_BITS (FRAC_BITS),
    .COORD_W   (COORD_W),
    .ACC_W     (ACC_W)
  ) u_acc (
    .clk         (clk),
    .reset       (reset),
    .setup_x     (setup_x),
    .setup_y     (setup_y),
    .step        (adv),
    .hflip       (m7sel[0]),
    .vflip       (m7sel[1]),
    .y           (y),
    .m7_a        (m7_a),
    .m7_b        (m7_b),
    .m7_c        (m7_c),
    .m7_d        (m7_d),
    .xofs        (m7_xofs),
    .yofs        (m7_yofs),
    .xorig       (m7_xorig),
    .yorig       (m7_yorig),
    .mosaic_en   (mosaic_en),
    .mosaic_size (mosaic_size),
    .accx        (accx),
    .accy        (accy)
  );

  // sign bits sit above the field, so negatives count as over
  assign over_now = |accx[ACC_W-1:OVL] | |accy[ACC_W-1:OVL];

  assign s1_tile_d = (ovf_q == M7_TILE0 && s0_over_q)
                   ? 8'h00 : vram_rdata_l;

  always_comb begin
    pix_d       = '0;
    pix_d.color = extbg ? {1'b0, s2_data_q[6:0]} : s2_data_q;
    pix_d.prio  = extbg & s2_data_q[7];
    pix_d.valid = (|pix_d.color)
                & ~(ovf_q == M7_TRANSPARENT && s2_over_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_px_q   <= '0;
      s0_py_q   <= '0;
      s0_over_q <= 1'b0;
      s1_tile_q <= '0;
      s1_fx_q   <= '0;
      s1_fy_q   <= '0;
      s1_over_q <= 1'b0;
      s2_data_q <= '0;
      s2_over_q <= 1'b0;
      pix_q     <= '0;
    end else if (adv) begin
      s0_px_q   <= accx[FRAC_BITS +: PXW];
      s0_py_q   <= accy[FRAC_BITS +: PXW];
      s0_over_q <= over_now;
      s1_tile_q <= s1_tile_d;
      s1_fx_q   <= s0_px_q[2:0];
      s1_fy_q   <= s0_py_q[2:0];
      s1_over_q <= s0_over_q;
      s2_data_q <= vram_rdata_h;
      s2_over_q <= s1_over_q;
      pix_q     <= pix_d;
    end
  end

  assign vram_l_addr = 15'({s0_py_q[PXW-1:3], s0_px_q[PXW-1:3]});
  assign vram_h_addr = 15'({s1_tile_q, s1_fy_q, s1_fx_q});

  assign pixel_color = pix_q.color;
  assign pixel_prio  = pix_q.prio;
  assign pixel_valid = pix_q.valid;

  assign unused_in = ^{x, m7sel[5:2],
                       accx[FRAC_BITS-1:0], accy[FRAC_BITS-1:0]};

endmodule

// File: tb/tb_bg7_engine.sv
// tb_bg7_engine: scoreboard bench for the Mode 7 engine with a
// behavioural VRAM and an integer model of the line geometry.
module tb_bg7_engine;

  logic        clk = 1'b0;
  logic        reset, dot_en, line_start;
  logic [7:0]  x, y, m7sel;
  logic [15:0] m7_a, m7_b, m7_c, m7_d;
  logic [12:0] m7_xofs, m7_yofs, m7_xorig, m7_yorig;
  logic [3:0]  mosaic_size;
  logic        mosaic_en, extbg;
  logic [14:0] vram_l_addr, vram_h_addr;
  logic [7:0]  vram_rdata_l, vram_rdata_h;
  logic [7:0]  pixel_color;
  logic        pixel_prio, pixel_valid, busy;

  int n_vec = 0;
  int n_err = 0;

  int ca, cb, cc, cd, xo, yo, xr, yr, mode, msz;
  bit hf, vf, mos, ext;

  logic [9:0]  pq[$];
  logic [14:0] hq[$];

  always #5 clk = ~clk;

  assign m7_a        = ca[15:0];
  assign m7_b        = cb[15:0];
  assign m7_c        = cc[15:0];
  assign m7_d        = cd[15:0];
  assign m7_xofs     = xo[12:0];
  assign m7_yofs     = yo[12:0];
  assign m7_xorig    = xr[12:0];
  assign m7_yorig    = yr[12:0];
  assign m7sel       = {mode[1:0], 4'b0000, vf, hf};
  assign mosaic_en   = mos;
  assign mosaic_size = msz[3:0];
  assign extbg       = ext;

  bg7_engine dut (
    .clk          (clk),
    .reset        (reset),
    .dot_en       (dot_en),
    .line_start   (line_start),
    .x            (x),
    .y            (y),
    .m7sel        (m7sel),
    .m7_a         (m7_a),
    .m7_b         (m7_b),
    .m7_c         (m7_c),
    .m7_d         (m7_d),
    .m7_xofs      (m7_xofs),
    .m7_yofs      (m7_yofs),
    .m7_xorig     (m7_xorig),
    .m7_yorig     (m7_yorig),
    .mosaic_size  (mosaic_size),
    .mosaic_en    (mosaic_en),
    .extbg        (extbg),
    .vram_l_addr  (vram_l_addr),
    .vram_h_addr  (vram_h_addr),
    .vram_rdata_l (vram_rdata_l),
    .vram_rdata_h (vram_rdata_h),
    .pixel_color  (pixel_color),
    .pixel_prio   (pixel_prio),
    .pixel_valid  (pixel_valid),
    .busy         (busy)
  );

  function automatic logic [7:0] tmap(input logic [14:0] a);
    if (a == 15'd0) return 8'd5;
    return a[7:0] ^ {1'b0, a[13:7]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] chr(input logic [14:0] a);
    logic [7:0] t;
    logic [2:0] r, c;
    t = a[13:6];
    r = a[5:3];
    c = a[2:0];
    if (t == 8'd5 && r == 3'd0) return {5'd0, c} + 8'd1;
    if (t == 8'd5 && r == 3'd1) begin
      if (c == 3'd0) return 8'h85;
      if (c == 3'd1) return 8'h80;
      return 8'h40 + {5'd0, c};
    end
    return 8'(a * 29 + 7);
  endfunction

  always @(posedge clk) begin
    vram_rdata_l <= tmap(vram_l_addr);
    vram_rdata_h <= chr(vram_h_addr);
  end

  // expected pixel and addresses for the k-th dot of the line
  function automatic void model(input int k,
                                output logic [9:0] pix,
                                output logic [14:0] la,
                                output logic [14:0] ha);
    longint x0, yp, ux, uy, n, ax, ay, cx, cy;
    int px, py;
    bit ov;
    logic [7:0] t, d, col;
    yp = vf ? 255 - int'(y) : int'(y);
    x0 = hf ? 255 : 0;
    ux = x0 + xo - xr;
    uy = yp + yo - yr;
    n  = mos ? k / (msz + 1) : k;
    ax = ca * ux + cb * uy + xr * 256 + (hf ? -ca : ca) * n;
    ay = cc * ux + cd * uy + yr * 256 + (hf ? -cc : cc) * n;
    cx = ax >>> 8;
    cy = ay >>> 8;
    px = int'(cx & 1023);
    py = int'(cy & 1023);
    ov = (cx < 0) || (cx > 1023) || (cy < 0) || (cy > 1023);
    la = 15'((py >> 3) * 128 + (px >> 3));
    t  = (mode == 3 && ov) ? 8'd0 : tmap(la);
    ha = 15'(int'(t) * 64 + (py & 7) * 8 + (px & 7));
    d  = chr(ha);
    col = ext ? {1'b0, d[6:0]} : d;
    pix = {col, ext & d[7],
           (col != 8'd0) && !(mode == 2 && ov)};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dot();
    repeat (2) @(negedge clk);
    dot_en = 1'b1;
    @(negedge clk);
    dot_en = 1'b0;
  endtask

  task automatic run_line(input int nd, input bit glitch);
    logic [9:0]  p;
    logic [14:0] la, ha;
    pq.delete();
    hq.delete();
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    if (glitch) begin
      check("busy_sx", 32'(busy), 1);
      @(negedge clk);
      check("busy_sy", 32'(busy), 1);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      check("busy_restart", 32'(busy), 1);
      @(negedge clk);
      check("busy_sy2", 32'(busy), 1);
      @(negedge clk);
      check("busy_run", 32'(busy), 0);
    end
    for (int j = 0; j < nd + 3; j++) begin
      model(j, p, la, ha);
      pq.push_back(p);
      hq.push_back(ha);
      x = 8'(j);
      dot();
      check("laddr", 32'(vram_l_addr), 32'(la));
      if (j >= 1)
        check("haddr", 32'(vram_h_addr), 32'(hq.pop_front()));
      if (j >= 3)
        check("pixel", 32'({pixel_color, pixel_prio, pixel_valid}),
              32'(pq.pop_front()));
    end
  endtask

  task automatic defaults();
    ca = 256; cb = 0; cc = 0; cd = 256;
    xo = 0; yo = 0; xr = 0; yr = 0;
    hf = 0; vf = 0; mode = 0; ext = 0;
    mos = 0; msz = 0; y = 8'd0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_color"}, 32'(pixel_color), 0);
    check({tag, "_prio"}, 32'(pixel_prio), 0);
    check({tag, "_valid"}, 32'(pixel_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_laddr"}, 32'(vram_l_addr), 0);
    check({tag, "_haddr"}, 32'(vram_h_addr), 0);
  endtask

  initial begin
    reset = 1'b1;
    dot_en = 1'b0;
    line_start = 1'b0;
    x = 8'd0;
    defaults();
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    run_line(8, 1'b0);

    ca = 128;
    run_line(8, 1'b0);

    ca = 256; hf = 1;
    run_line(8, 1'b0);

    hf = 0; xo = -8; mode = 2;
    run_line(12, 1'b0);
    mode = 3;
    run_line(12, 1'b0);
    mode = 0;
    run_line(12, 1'b0);

    defaults();
    mos = 1; msz = 3; ca = 1024;
    run_line(12, 1'b0);

    defaults();
    ext = 1; y = 8'd1;
    run_line(8, 1'b0);

    defaults();
    ca = 221; cb = 64; cc = -64; cd = 221;
    xr = 64; yr = 32; xo = 20; yo = -10;
    vf = 1; y = 8'd100;
    run_line(10, 1'b0);

    defaults();
    run_line(8, 1'b1);

    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    dot();
    check("idle_busy", 32'(busy), 0);
    check("idle_color", 32'(pixel_color), 0);
    check("idle_valid", 32'(pixel_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
